// File: rtl/kbest_merge_elect_pkg.sv
// Shared parameters for the K-best survivor election: word widths,
// children per parent, pointer width and list slice offsets.
package kbest_merge_elect_pkg;

  // PED word width used across the detector datapath.
  localparam int ERR_WL   = 16;

  // Children enumerated per surviving parent (one list per parent).
  localparam int CHILDREN = 4;

  // List pointer must reach CHILDREN to mark an exhausted list.
  localparam int PTR_W    = $clog2(CHILDREN + 1);

  // Bits needed to address an entry inside one list.
  localparam int EW       = $clog2(CHILDREN);

  typedef enum logic {
    IDLE  = 1'b0,
    ELECT = 1'b1
  } state_t;

  // Bit offset of entry `entry` of list `list` in a flattened bus.
  function automatic int slice_off(input int list, input int entry, input int width);
    return (list * CHILDREN + entry) * width;
  endfunction

endpackage

// File: rtl/kbest_min_tree.sv
// Combinational minimum tree over K list heads. Exhausted heads are
// masked by their valid flag. Strict "<" keeps the left (lower index)
// operand on ties, so the lowest list index wins equal PEDs.
module kbest_min_tree #(
  parameter int K     = 4,
  parameter int PED_W = 16,
  parameter int IDX_W = $clog2(K)
) (
  input  logic [K*PED_W-1:0] head_ped,
  input  logic [K-1:0]       head_valid,
  output logic [IDX_W-1:0]   win_idx,
  output logic [PED_W-1:0]   win_ped
);

  localparam int LVLS = $clog2(K);

  logic [PED_W-1:0] lvl_ped [K];
  logic [IDX_W-1:0] lvl_idx [K];
  logic             lvl_vld [K];
  logic             take_r;

  // Reduce pairwise in place, log2(K) levels; slot 0 ends up holding the winner.
  always_comb begin
    take_r = 1'b0;
    for (int i = 0; i < K; i++) begin
      lvl_ped[i] = head_ped[i*PED_W +: PED_W];
      lvl_idx[i] = IDX_W'(i);
      lvl_vld[i] = head_valid[i];
    end
    for (int l = 0; l < LVLS; l++) begin
      for (int i = 0; i < K/2; i++) begin
        if (i < (K >> (l + 1))) begin
          take_r = lvl_vld[2*i+1] &&
                   (!lvl_vld[2*i] || (lvl_ped[2*i+1] < lvl_ped[2*i]));
          if (take_r) begin
            lvl_ped[i] = lvl_ped[2*i+1];
            lvl_idx[i] = lvl_idx[2*i+1];
            lvl_vld[i] = lvl_vld[2*i+1];
          end else begin
            lvl_ped[i] = lvl_ped[2*i];
            lvl_idx[i] = lvl_idx[2*i];
            lvl_vld[i] = lvl_vld[2*i];
          end
        end
      end
    end
    win_idx = lvl_idx[0];
    win_ped = lvl_ped[0];
  end

endmodule

// File: rtl/kbest_merge_elect.sv
// K-best survivor election: stores K sorted-head candidate lists and
// streams the K smallest-PED survivors by repeatedly popping the
// smallest list head, one survivor per cycle under valid/ready.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a list set; LOAD_ready high
// ELECT | popping heads into the output register until OUT_last accepted
module kbest_merge_elect
  import kbest_merge_elect_pkg::*;
#(
  parameter int K     = 4,
  parameter int N     = 2,
  parameter int PED_W = ERR_WL
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        LOAD_valid,
  output logic                        LOAD_ready,
  input  logic [K*CHILDREN*N*2-1:0]   PATH_in,
  input  logic [K*CHILDREN*PED_W-1:0] PED_in,
  output logic                        OUT_valid,
  input  logic                        OUT_ready,
  output logic [N*2-1:0]              OUT_PATH,
  output logic [PED_W-1:0]            OUT_PED,
  output logic [$clog2(K)-1:0]        OUT_src,
  output logic                        OUT_last
);

  localparam int PW      = N * 2;
  localparam int ENTRIES = K * CHILDREN;
  localparam int IDX_W   = $clog2(K);
  localparam int CNT_W   = $clog2(K + 1);

  state_t           state_q, state_d;
  logic [PW-1:0]    path_q [ENTRIES];
  logic [PED_W-1:0] ped_q  [ENTRIES];
  logic [PTR_W-1:0] ptr_q  [K];
  logic [CNT_W-1:0] cnt_q;

  logic             out_valid_q, out_last_q;
  logic [PW-1:0]    out_path_q;
  logic [PED_W-1:0] out_ped_q;
  logic [IDX_W-1:0] out_src_q;

  logic             load_fire, pop, done;
  logic [K*PED_W-1:0] head_ped;
  logic [K-1:0]     head_valid;
  logic [IDX_W-1:0] win_idx;
  logic [PED_W-1:0] win_ped;
  logic [PW-1:0]    win_path;

  // Present each list's current head; a pointer at CHILDREN masks the list.
  always_comb begin
    head_ped   = '0;
    head_valid = '0;
    for (int j = 0; j < K; j++) begin
      head_valid[j]              = (ptr_q[j] != PTR_W'(CHILDREN));
      head_ped[j*PED_W +: PED_W] = ped_q[j*CHILDREN + int'(ptr_q[j][EW-1:0])];
    end
  end

  kbest_min_tree #(
    .K     (K),
    .PED_W (PED_W),
    .IDX_W (IDX_W)
  ) u_min_tree (
    .head_ped   (head_ped),
    .head_valid (head_valid),
    .win_idx    (win_idx),
    .win_ped    (win_ped)
  );

  // Fetch the path that belongs to the winning head.
  always_comb begin
    win_path = path_q[int'(win_idx)*CHILDREN + int'(ptr_q[win_idx][EW-1:0])];
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and per-cycle actions: load, pop a survivor, or finish the set.
  always_comb begin
    state_d   = state_q;
    load_fire = 1'b0;
    pop       = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (LOAD_valid) begin
          load_fire = 1'b1;
          state_d   = ELECT;
        end
      end
      ELECT: begin
        if (out_valid_q && out_last_q) begin
          if (OUT_ready) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end else if (!out_valid_q || OUT_ready) begin
          pop = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // List storage; only meaningful after a load, so no reset needed.
  always_ff @(posedge CLK) begin
    if (load_fire) begin
      for (int j = 0; j < K; j++) begin
        for (int e = 0; e < CHILDREN; e++) begin
          ped_q[j*CHILDREN+e]  <= PED_in[slice_off(j, e, PED_W) +: PED_W];
          path_q[j*CHILDREN+e] <= PATH_in[slice_off(j, e, PW) +: PW];
        end
      end
    end
  end

  // Pointers, survivor count and the output register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int j = 0; j < K; j++) ptr_q[j] <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_path_q  <= '0;
      out_ped_q   <= '0;
      out_src_q   <= '0;
    end else begin
      if (load_fire) begin
        for (int j = 0; j < K; j++) ptr_q[j] <= '0;
        cnt_q <= '0;
      end
      if (pop) begin
        out_valid_q     <= 1'b1;
        out_path_q      <= win_path;
        out_ped_q       <= win_ped;
        out_src_q       <= win_idx;
        out_last_q      <= ((cnt_q + CNT_W'(1)) == CNT_W'(K));
        ptr_q[win_idx]  <= ptr_q[win_idx] + PTR_W'(1);
        cnt_q           <= cnt_q + CNT_W'(1);
      end
      if (done) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign LOAD_ready = (state_q == IDLE);
  assign OUT_valid  = out_valid_q;
  assign OUT_PATH   = out_path_q;
  assign OUT_PED    = out_ped_q;
  assign OUT_src    = out_src_q;
  assign OUT_last   = out_last_q;

endmodule

// File: tb/tb_kbest_merge_elect.sv
// Self-checking bench for kbest_merge_elect. Expected survivors come from
// a pool-based merge model: at each step the eligible candidates are the
// earliest remaining entry of every list, and the smallest PED is taken.
module tb_kbest_merge_elect;

  localparam int K     = 4;
  localparam int N     = 2;
  localparam int PED_W = 16;
  localparam int PW    = N * 2;
  localparam int IDX_W = 2;

  logic                    CLK = 1'b0;
  logic                    RST, LOAD_valid, LOAD_ready;
  logic [K*4*PW-1:0]       PATH_in;
  logic [K*4*PED_W-1:0]    PED_in;
  logic                    OUT_valid, OUT_ready, OUT_last;
  logic [PW-1:0]           OUT_PATH;
  logic [PED_W-1:0]        OUT_PED;
  logic [IDX_W-1:0]        OUT_src;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  int sp [K][4];
  int sa [K][4];
  int e_ped [K], e_path [K], e_src [K];
  int o_ped [K], o_path [K], o_src [K], o_last [K], o_cyc [K];
  int o_n;
  int load_cyc;

  typedef struct {int ped; int path; int src;} cand_t;

  kbest_merge_elect dut (
    .CLK        (CLK),
    .RST        (RST),
    .LOAD_valid (LOAD_valid),
    .LOAD_ready (LOAD_ready),
    .PATH_in    (PATH_in),
    .PED_in     (PED_in),
    .OUT_valid  (OUT_valid),
    .OUT_ready  (OUT_ready),
    .OUT_PATH   (OUT_PATH),
    .OUT_PED    (OUT_PED),
    .OUT_src    (OUT_src),
    .OUT_last   (OUT_last)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic model();
    cand_t pool[$];
    cand_t c;
    bit    seen [K];
    int    best;
    pool.delete();
    for (int j = 0; j < K; j++)
      for (int e = 0; e < 4; e++) begin
        c.ped = sp[j][e]; c.path = sa[j][e]; c.src = j;
        pool.push_back(c);
      end
    for (int k = 0; k < K; k++) begin
      for (int j = 0; j < K; j++) seen[j] = 1'b0;
      best = -1;
      for (int i = 0; i < pool.size(); i++) begin
        if (!seen[pool[i].src]) begin
          seen[pool[i].src] = 1'b1;
          if (best < 0 || pool[i].ped < pool[best].ped ||
              (pool[i].ped == pool[best].ped && pool[i].src < pool[best].src))
            best = i;
        end
      end
      e_ped[k]  = pool[best].ped;
      e_path[k] = pool[best].path;
      e_src[k]  = pool[best].src;
      pool.delete(best);
    end
  endtask

  task automatic rand_paths();
    for (int j = 0; j < K; j++)
      for (int e = 0; e < 4; e++) sa[j][e] = int'($urandom_range(0, 15));
  endtask

  task automatic do_load();
    @(negedge CLK);
    for (int j = 0; j < K; j++)
      for (int e = 0; e < 4; e++) begin
        PED_in[(j*4+e)*PED_W +: PED_W] = sp[j][e][PED_W-1:0];
        PATH_in[(j*4+e)*PW +: PW]      = sa[j][e][PW-1:0];
      end
    LOAD_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    LOAD_valid = 1'b0;
    for (int i = 0; i < K*4; i++) begin
      PED_in[i*PED_W +: PED_W] = PED_W'($urandom);
      PATH_in[i*PW +: PW]      = PW'($urandom);
    end
    load_cyc = cyc;
    o_n = 0;
  endtask

  task automatic drain(input bit rnd);
    int guard = 0;
    while (o_n < K && guard < 64) begin
      OUT_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (OUT_valid && OUT_ready) begin
        o_ped[o_n]  = int'(OUT_PED);
        o_path[o_n] = int'(OUT_PATH);
        o_src[o_n]  = int'(OUT_src);
        o_last[o_n] = int'(OUT_last);
        o_cyc[o_n]  = cyc;
        o_n++;
      end
      @(posedge CLK);
      @(negedge CLK);
      guard++;
    end
    n_chk++;
    if (o_n !== K) begin
      n_err++;
      $display("FAIL drain_timeout: beats=%0d required=%0d", o_n, K);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; LOAD_valid = 1'b0; OUT_ready = 1'b0;
    PATH_in = '0; PED_in = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_chk++;
    if (LOAD_ready !== 1'b1 || OUT_valid !== 1'b0 || OUT_PED !== '0 ||
        OUT_last !== 1'b0 || OUT_src !== '0 || OUT_PATH !== '0) begin
      n_err++;
      $display("FAIL reset: ready=%b valid=%b ped=%0d last=%b src=%0d path=%0d required 1 0 0 0 0 0",
               LOAD_ready, OUT_valid, OUT_PED, OUT_last, OUT_src, OUT_PATH);
    end
    RST = 1'b0;
  endtask

  task automatic test_basic();
    for (int j = 0; j < K; j++)
      for (int e = 0; e < 4; e++) sp[j][e] = (e == 0) ? 10*(j+1) : 99;
    for (int e = 0; e < 4; e++) sp[0][e] = 10 + e;
    rand_paths();
    model();
    do_load();
    n_chk++;
    if (OUT_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_early_valid: valid=%b required 0", OUT_valid);
    end
    drain(1'b0);
    for (int i = 0; i < K; i++) begin
      n_chk++;
      if (o_ped[i] !== e_ped[i] || o_src[i] !== e_src[i] || o_path[i] !== e_path[i] ||
          o_last[i] !== int'(i == K-1) || o_cyc[i] !== load_cyc + 1 + i) begin
        n_err++;
        $display("FAIL basic_beat%0d: ped=%0d src=%0d path=%0d last=%0d cyc=%0d required %0d %0d %0d %0d %0d",
                 i, o_ped[i], o_src[i], o_path[i], o_last[i], o_cyc[i] - load_cyc,
                 e_ped[i], e_src[i], e_path[i], int'(i == K-1), i + 1);
      end
    end
    n_chk++;
    if (LOAD_ready !== 1'b1 || OUT_valid !== 1'b0 || cyc !== load_cyc + K + 1) begin
      n_err++;
      $display("FAIL basic_done: ready=%b valid=%b at +%0d required 1 0 at +%0d",
               LOAD_ready, OUT_valid, cyc - load_cyc, K + 1);
    end
  endtask

  task automatic test_spread();
    for (int j = 0; j < K; j++)
      for (int e = 0; e < 4; e++) sp[j][e] = j*4 + 1 + 16*e;
    rand_paths();
    model();
    do_load();
    drain(1'b0);
    for (int i = 0; i < K; i++) begin
      n_chk++;
      if (o_ped[i] !== e_ped[i] || o_src[i] !== e_src[i] || o_path[i] !== e_path[i] ||
          o_last[i] !== int'(i == K-1)) begin
        n_err++;
        $display("FAIL spread_beat%0d: ped=%0d src=%0d path=%0d last=%0d required %0d %0d %0d %0d",
                 i, o_ped[i], o_src[i], o_path[i], o_last[i], e_ped[i], e_src[i], e_path[i], int'(i == K-1));
      end
    end
  endtask

  task automatic test_tie();
    for (int j = 0; j < K; j++)
      for (int e = 0; e < 4; e++) sp[j][e] = (e == 0) ? 7 : 50;
    rand_paths();
    model();
    do_load();
    drain(1'b0);
    for (int i = 0; i < K; i++) begin
      n_chk++;
      if (o_ped[i] !== e_ped[i] || o_src[i] !== e_src[i] || o_path[i] !== e_path[i]) begin
        n_err++;
        $display("FAIL tie_beat%0d: ped=%0d src=%0d path=%0d required %0d %0d %0d",
                 i, o_ped[i], o_src[i], o_path[i], e_ped[i], e_src[i], e_path[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [PED_W-1:0] h_ped;
    logic [PW-1:0]    h_path;
    logic [IDX_W-1:0] h_src;
    logic             h_last;
    for (int j = 0; j < K; j++)
      for (int e = 0; e < 4; e++) sp[j][e] = int'($urandom_range(1, 40));
    rand_paths();
    model();
    do_load();
    OUT_ready = 1'b1;
    @(posedge CLK); @(negedge CLK);
    o_ped[0] = int'(OUT_PED); o_path[0] = int'(OUT_PATH);
    o_src[0] = int'(OUT_src); o_last[0] = int'(OUT_last);
    o_n = 1;
    @(posedge CLK); @(negedge CLK);
    OUT_ready = 1'b0;
    h_ped = OUT_PED; h_path = OUT_PATH; h_src = OUT_src; h_last = OUT_last;
    for (int s = 0; s < 3; s++) begin
      if (s == 1) begin
        LOAD_valid = 1'b1;
        PED_in = '0;
      end
      @(posedge CLK); @(negedge CLK);
      LOAD_valid = 1'b0;
      n_chk++;
      if (OUT_valid !== 1'b1 || OUT_PED !== h_ped || OUT_PATH !== h_path ||
          OUT_src !== h_src || OUT_last !== h_last) begin
        n_err++;
        $display("FAIL stall_hold%0d: valid=%b ped=%0d src=%0d path=%0d required 1 %0d %0d %0d",
                 s, OUT_valid, OUT_PED, OUT_src, OUT_PATH, h_ped, h_src, h_path);
      end
    end
    drain(1'b0);
    for (int i = 0; i < K; i++) begin
      n_chk++;
      if (o_ped[i] !== e_ped[i] || o_src[i] !== e_src[i] || o_path[i] !== e_path[i] ||
          o_last[i] !== int'(i == K-1)) begin
        n_err++;
        $display("FAIL bp_beat%0d: ped=%0d src=%0d path=%0d last=%0d required %0d %0d %0d %0d",
                 i, o_ped[i], o_src[i], o_path[i], o_last[i], e_ped[i], e_src[i], e_path[i], int'(i == K-1));
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int j = 0; j < K; j++)
      for (int e = 0; e < 4; e++) sp[j][e] = int'($urandom_range(0, 100));
    rand_paths();
    do_load();
    OUT_ready = 1'b1;
    repeat (3) begin @(posedge CLK); @(negedge CLK); end
    RST = 1'b1;
    @(posedge CLK); @(negedge CLK);
    n_chk++;
    if (OUT_valid !== 1'b0 || LOAD_ready !== 1'b1 || OUT_last !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: valid=%b ready=%b last=%b required 0 1 0", OUT_valid, LOAD_ready, OUT_last);
    end
    RST = 1'b0;
    for (int j = 0; j < K; j++)
      for (int e = 0; e < 4; e++) sp[j][e] = int'($urandom_range(0, 100));
    rand_paths();
    model();
    do_load();
    drain(1'b0);
    for (int i = 0; i < K; i++) begin
      n_chk++;
      if (o_ped[i] !== e_ped[i] || o_src[i] !== e_src[i] || o_path[i] !== e_path[i] ||
          o_last[i] !== int'(i == K-1)) begin
        n_err++;
        $display("FAIL rmid_beat%0d: ped=%0d src=%0d path=%0d last=%0d required %0d %0d %0d %0d",
                 i, o_ped[i], o_src[i], o_path[i], o_last[i], e_ped[i], e_src[i], e_path[i], int'(i == K-1));
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      for (int j = 0; j < K; j++)
        for (int e = 0; e < 4; e++)
          sp[j][e] = (t < 5) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 65535));
      rand_paths();
      model();
      do_load();
      drain(1'b1);
      for (int i = 0; i < K; i++) begin
        n_chk++;
        if (o_ped[i] !== e_ped[i] || o_src[i] !== e_src[i] || o_path[i] !== e_path[i] ||
            o_last[i] !== int'(i == K-1)) begin
          n_err++;
          $display("FAIL rand%0d_beat%0d: ped=%0d src=%0d path=%0d last=%0d required %0d %0d %0d %0d",
                   t, i, o_ped[i], o_src[i], o_path[i], o_last[i], e_ped[i], e_src[i], e_path[i], int'(i == K-1));
        end
      end
      n_chk++;
      if (LOAD_ready !== 1'b1 || OUT_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rand%0d_done: ready=%b valid=%b required 1 0", t, LOAD_ready, OUT_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_spread();
    test_tie();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
